// File: rtl/pool_bram_writer_pkg.sv
// Shared layer geometry, BRAM address layout and state/layer enums for the pooling
// output buffer writer. The same constants describe the layout the BRAM DMA reads.
package pool_bram_writer_pkg;

  localparam int SRC_DEPTH   = 1024;
  localparam int SRC_WIDTH   = 16;
  localparam int DATA_WIDTH  = 8;
  localparam int CONV1_BURST = 196;
  localparam int CONV2_BURST = 100;
  localparam int CONV1_CH    = 6;
  localparam int CONV2_CH    = 16;

  localparam int WORD_W = $clog2(SRC_DEPTH);
  localparam int BANK_W = $clog2(SRC_WIDTH);
  localparam int ADDR_W = WORD_W + BANK_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CONV1 = 2'd0,
    CONV2 = 2'd1
  } layer_e;

  // Terminal values are stored pre-decremented so the wrap compares need no subtractor.
  typedef struct packed {
    logic [WORD_W-1:0] burst_last;
    logic [BANK_W-1:0] bank_last;
    logic [WORD_W-1:0] base;
  } layer_cfg_t;

  function automatic layer_cfg_t layer_cfg(input logic sel_conv2);
    layer_cfg_t cfg;
    if (sel_conv2) begin
      cfg.burst_last = WORD_W'(CONV2_BURST - 1);
      cfg.bank_last  = BANK_W'(CONV2_CH - 1);
      cfg.base       = WORD_W'(CONV1_BURST);
    end else begin
      cfg.burst_last = WORD_W'(CONV1_BURST - 1);
      cfg.bank_last  = BANK_W'(CONV1_CH - 1);
      cfg.base       = '0;
    end
    return cfg;
  endfunction

endpackage

// File: rtl/pool_bram_writer_if.sv
// Pooled-activation stream plus BRAM write port. The slave modport is the writer's
// view; the master modport is the stream source / BRAM observer side.
interface pool_bram_writer_if;
  import pool_bram_writer_pkg::*;

  logic                  s_valid_i;
  logic [DATA_WIDTH-1:0] s_data_i;
  logic                  s_ready_o;
  logic                  ena_o;
  logic                  wea_o;
  logic [ADDR_W-1:0]     addra_o;
  logic [DATA_WIDTH-1:0] dia_o;

  modport slave (
    input  s_valid_i, s_data_i,
    output s_ready_o, ena_o, wea_o, addra_o, dia_o
  );

  modport master (
    output s_valid_i, s_data_i,
    input  s_ready_o, ena_o, wea_o, addra_o, dia_o
  );

endinterface

// File: rtl/pool_bram_writer_bank_addr_gen.sv
// Channel-major bank/index counters for the pooling writer; forms {bank, base+index}
// and flags the final beat of the layer.
module bank_addr_gen
  import pool_bram_writer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  layer_cfg_t        cfg_i,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  layer_cfg_t        cfg_q;
  logic [BANK_W-1:0] bank;
  logic [WORD_W-1:0] idx;
  logic              idx_wrap;

  assign idx_wrap = (idx == cfg_q.burst_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q <= '0;
      bank  <= '0;
      idx   <= '0;
    end else if (load) begin
      cfg_q <= cfg_i;
      bank  <= '0;
      idx   <= '0;
    end else if (advance) begin
      if (idx_wrap) begin
        idx  <= '0;
        bank <= bank + 1'b1;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  // base+index tops out at 295, so the word field never overflows
  assign addr = {bank, cfg_q.base + idx};
  assign last = idx_wrap && (bank == cfg_q.bank_last);

endmodule

// File: rtl/pool_bram_writer.sv
// Streams pooled activations into the 16-bank source BRAM channel-major and pulses
// done_o after the last write. Optional stall counter: POOL_WR_STALL_CNT_EN.
module pool_bram_writer
  import pool_bram_writer_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [1:0]          nth_conv_i,
  pool_bram_writer_if.slave   bus,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [15:0]         stall_cnt_o
);

  localparam logic [1:0] ST_IDLE  = S_IDLE;
  localparam logic [1:0] ST_WRITE = S_WRITE;
  localparam logic [1:0] ST_DONE  = S_DONE;

  logic [1:0]            state;
  logic                  in_idle;
  logic                  start_ok;
  logic                  accept;
  logic                  last_beat;
  logic [ADDR_W-1:0]     gen_addr;
  logic                  wr_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  err_q;

  assign in_idle  = (state == ST_IDLE);
  assign start_ok = in_idle && start_i && !nth_conv_i[1];
  assign accept   = bus.s_valid_i && (state == ST_WRITE);

  bank_addr_gen u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (start_ok),
    .cfg_i   (layer_cfg(nth_conv_i[0])),
    .advance (accept),
    .addr    (gen_addr),
    .last    (last_beat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start_ok) state <= ST_WRITE;
        ST_WRITE: if (accept && last_beat) state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wr_q  <= accept;
      err_q <= in_idle && start_i && nth_conv_i[1];
      if (accept) begin
        addr_q <= gen_addr;
        data_q <= bus.s_data_i;
      end
    end
  end

  // ready is decoded from state only, so it never combinationally follows valid
  assign bus.s_ready_o = (state == ST_WRITE);
  assign bus.ena_o     = wr_q;
  assign bus.wea_o     = wr_q;
  assign bus.addra_o   = addr_q;
  assign bus.dia_o     = data_q;
  assign busy_o        = !in_idle;
  assign done_o        = (state == ST_DONE);
  assign err_o         = err_q;

`ifdef POOL_WR_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (start_ok) begin
      stall_q <= '0;
    end else if ((state == ST_WRITE) && !bus.s_valid_i && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pool_bram_writer.sv
// Directed bench for pool_bram_writer: full conv1/conv2 layers, random backpressure,
// illegal layer select, ignored mid-transfer start and mid-transfer reset.
module tb_pool_bram_writer;
  import pool_bram_writer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  nth_conv = 2'd0;
  logic        busy, done, err;
  logic [15:0] stall_cnt;

  pool_bram_writer_if bus();

  pool_bram_writer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .nth_conv_i  (nth_conv),
    .bus         (bus),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .stall_cnt_o (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // write monitor with an independent channel-major address model
  int          wr_cnt, addr_err, ena_err, data_err, done_cnt, tb_stall;
  int          m_bank, m_idx, cfg_burst, cfg_base;
  logic [13:0] first_addr, mark_addr, last_addr, exp_addr;
  logic        done_with_write, prev_accept, mon_clr;
  logic [7:0]  prev_data;

  initial mon_clr = 1'b1;

  always @(negedge clk) begin
    if (mon_clr) begin
      wr_cnt = 0; addr_err = 0; ena_err = 0; data_err = 0; done_cnt = 0; tb_stall = 0;
      m_bank = 0; m_idx = 0; first_addr = '0; mark_addr = '0; last_addr = '0;
      done_with_write = 1'b0; prev_accept = 1'b0; prev_data = '0;
    end else if (!rst_n) begin
      prev_accept = 1'b0;
    end else begin
      if ((bus.ena_o !== prev_accept) || (bus.wea_o !== prev_accept)) ena_err++;
      if (bus.ena_o && bus.wea_o) begin
        exp_addr = 14'(m_bank * 1024 + cfg_base + m_idx);
        if (bus.addra_o !== exp_addr) addr_err++;
        if (bus.dia_o !== prev_data) data_err++;
        if (wr_cnt == 0) first_addr = bus.addra_o;
        if (wr_cnt == cfg_burst) mark_addr = bus.addra_o;
        last_addr = bus.addra_o;
        wr_cnt++;
        if (m_idx == cfg_burst - 1) begin
          m_idx = 0;
          m_bank++;
        end else begin
          m_idx++;
        end
      end
      if (done) begin
        done_cnt++;
        done_with_write = bus.ena_o;
      end
      if (bus.s_ready_o && !bus.s_valid_i) tb_stall++;
      prev_accept = bus.s_ready_o && bus.s_valid_i;
      prev_data   = bus.s_data_i;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic mon_reset(input int burst, input int base);
    cfg_burst = burst;
    cfg_base  = base;
    mon_clr   = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic start_layer(input logic [1:0] sel);
    @(posedge clk);
    #1 start = 1'b1; nth_conv = sel;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input bit rnd, input int budget, output int cyc);
    cyc = -1;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk);
      #1;
      bus.s_data_i = 8'($urandom);
      if (rnd) bus.s_valid_i = 1'($urandom_range(0, 1));
      if (done) begin
        cyc = c;
        break;
      end
    end
    bus.s_valid_i = 1'b0;
    if (cyc < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  int cyc;

  initial begin
    bus.s_valid_i = 1'b0;
    bus.s_data_i  = 8'h00;

    // reset values
    #1;
    check("rst_ena",   {31'd0, bus.ena_o},     32'd0);
    check("rst_wea",   {31'd0, bus.wea_o},     32'd0);
    check("rst_addra", {18'd0, bus.addra_o},   32'd0);
    check("rst_dia",   {24'd0, bus.dia_o},     32'd0);
    check("rst_ready", {31'd0, bus.s_ready_o}, 32'd0);
    check("rst_flags", {29'd0, busy, done, err}, 32'd0);
    check("rst_stall", {16'd0, stall_cnt},     32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // conv1, valid held high
    mon_reset(196, 0);
    bus.s_valid_i = 1'b1;
    bus.s_data_i  = 8'h5A;
    start_layer(2'd0);
    wait_done(1'b0, 2000, cyc);
    @(negedge clk); #1;
    check("c1_latency",   32'(cyc + 1),  32'd1177);
    check("c1_first",     {18'd0, first_addr}, 32'd0);
    check("c1_beat196",   {18'd0, mark_addr},  32'h400);
    check("c1_last",      {18'd0, last_addr},  32'd5315);
    check("c1_writes",    32'(wr_cnt),   32'd1176);
    check("c1_done_cnt",  32'(done_cnt), 32'd1);
    check("c1_done_wr",   {31'd0, done_with_write}, 32'd1);
    check("c1_addr_err",  32'(addr_err), 32'd0);
    check("c1_data_err",  32'(data_err), 32'd0);
    check("c1_ena_err",   32'(ena_err),  32'd0);
    check("c1_stall",     {16'd0, stall_cnt}, 32'd0);
    @(posedge clk); #1;
    check("c1_busy_fall", {31'd0, busy}, 32'd0);

    // conv2, valid held high
    mon_reset(100, 196);
    bus.s_valid_i = 1'b1;
    start_layer(2'd1);
    wait_done(1'b0, 2500, cyc);
    @(negedge clk); #1;
    check("c2_latency",  32'(cyc + 1),  32'd1601);
    check("c2_first",    {18'd0, first_addr}, 32'd196);
    check("c2_beat100",  {18'd0, mark_addr},  32'd1220);
    check("c2_last",     {18'd0, last_addr},  32'd15655);
    check("c2_writes",   32'(wr_cnt),   32'd1600);
    check("c2_done_cnt", 32'(done_cnt), 32'd1);
    check("c2_done_wr",  {31'd0, done_with_write}, 32'd1);
    check("c2_addr_err", 32'(addr_err), 32'd0);

    // conv1 with 50% random valid
    mon_reset(196, 0);
    bus.s_valid_i = 1'($urandom_range(0, 1));
    start_layer(2'd0);
    wait_done(1'b1, 5000, cyc);
    @(negedge clk); #1;
    check("rnd_writes",   32'(wr_cnt),   32'd1176);
    check("rnd_addr_err", 32'(addr_err), 32'd0);
    check("rnd_data_err", 32'(data_err), 32'd0);
    check("rnd_ena_err",  32'(ena_err),  32'd0);
    check("rnd_last",     {18'd0, last_addr}, 32'd5315);
    check("rnd_latency",  32'(cyc),      32'(1176 + tb_stall));
`ifdef POOL_WR_STALL_CNT_EN
    check("rnd_stall_cnt", {16'd0, stall_cnt}, 32'(tb_stall));
`else
    check("rnd_stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif

    // illegal layer select
    mon_reset(196, 0);
    bus.s_valid_i = 1'b1;
    start_layer(2'd2);
    check("err_pulse", {31'd0, err},           32'd1);
    check("err_busy",  {31'd0, busy},          32'd0);
    check("err_ready", {31'd0, bus.s_ready_o}, 32'd0);
    @(posedge clk); #1;
    check("err_once",  {31'd0, err},           32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("err_no_wr", 32'(wr_cnt), 32'd0);
    check("err_idle",  {30'd0, busy, bus.s_ready_o}, 32'd0);
    bus.s_valid_i = 1'b0;

    // start re-pulsed mid-transfer (conv2 select) must be ignored
    mon_reset(196, 0);
    bus.s_valid_i = 1'b1;
    start_layer(2'd0);
    repeat (300) @(posedge clk);
    start_layer(2'd1);
    wait_done(1'b0, 2000, cyc);
    @(negedge clk); #1;
    check("mid_start_writes", 32'(wr_cnt),   32'd1176);
    check("mid_start_addr",   32'(addr_err), 32'd0);
    check("mid_start_done",   32'(done_cnt), 32'd1);
    check("mid_start_lat",    32'(cyc + 1 + 302), 32'd1177);

    // reset asserted around beat 500 of conv2
    mon_reset(100, 196);
    bus.s_valid_i = 1'b1;
    start_layer(2'd1);
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk); #1;
      if (wr_cnt >= 500) break;
    end
    check("mr_reached_500", 32'(wr_cnt >= 500), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_ena_wea", {30'd0, bus.ena_o, bus.wea_o}, 32'd0);
    check("mr_addra",   {18'd0, bus.addra_o}, 32'd0);
    check("mr_dia",     {24'd0, bus.dia_o},   32'd0);
    check("mr_flags",   {28'd0, bus.s_ready_o, busy, done, err}, 32'd0);
    check("mr_stall",   {16'd0, stall_cnt},   32'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("mr_no_done", 32'(done_cnt), 32'd0);
    check("mr_addr_err", 32'(addr_err), 32'd0);

    mon_reset(196, 0);
    bus.s_valid_i = 1'b1;
    start_layer(2'd0);
    wait_done(1'b0, 2000, cyc);
    @(negedge clk); #1;
    check("post_rst_first",  {18'd0, first_addr}, 32'd0);
    check("post_rst_last",   {18'd0, last_addr},  32'd5315);
    check("post_rst_writes", 32'(wr_cnt),   32'd1176);
    check("post_rst_done",   32'(done_cnt), 32'd1);
    check("post_rst_addr",   32'(addr_err), 32'd0);
    check("post_rst_ena",    32'(ena_err),  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
